trigger_sequencer: RTL and testbench

TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

---
 rtl/trigger_seq_pkg.sv | 15 +
 rtl/trigger_seq_counter.sv | 26 ++
 rtl/trigger_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_trigger_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_seq_pkg.sv
// Shared types and default sizing for the trigger sequencer.
package trigger_seq_pkg;

  localparam int DEFAULT_CNT_W      = 32;
  localparam int DEFAULT_NUM_EVENTS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_WAIT_OFFSET,
    ST_PULSE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/trigger_seq_counter.sv
// Loadable down-counter with a zero flag; it saturates at zero instead of wrapping.
module trigger_seq_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (dec && count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/trigger_sequencer.sv
// Armed trigger sequencer issuing up to NUM_EVENTS delayed glitch pulses per trigger edge.
// Optional ARMED timeout is built only when TRIGGER_SEQ_TIMEOUT_EN is defined.
module trigger_sequencer
  import trigger_seq_pkg::*;
#(
  parameter int NUM_EVENTS = DEFAULT_NUM_EVENTS,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        arm,
  input  logic                        abort,
  input  logic                        trig_in,
  input  logic [NUM_EVENTS*CNT_W-1:0] offsets,
  input  logic [15:0]                 pulse_width,
  input  logic [4:0]                  num_events,
  input  logic [CNT_W-1:0]            timeout,
  output logic                        glitch_out,
  output logic                        armed,
  output logic                        busy,
  output logic [3:0]                  event_idx,
  output logic                        done,
  output logic                        timed_out
);

  state_t           state_q, state_d;
  logic             trig_prev;
  logic [CNT_W-1:0] off_q [NUM_EVENTS];
  logic [15:0]      width_q;
  logic [4:0]       count_q;
  logic [3:0]       idx_d;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_value;
  logic [CNT_W-1:0] next_off, width_load, gap_load;
  logic             trig_edge, is_last, capture;

  assign trig_edge = trig_in & ~trig_prev;
  assign capture   = (state_q == ST_IDLE) && arm && !abort;
  assign is_last   = (({1'b0, event_idx} + 5'd1) == count_q);

  // NOTE: configuration registers get a reset like any other state so a
  // post-reset sequence never sees stale offsets.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_EVENTS; i++) off_q[i] <= '0;
      width_q <= '0;
      count_q <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_EVENTS; i++) off_q[i] <= offsets[i*CNT_W +: CNT_W];
      width_q <= pulse_width;
      if (num_events == 5'd0)
        count_q <= 5'd1;
      else if (num_events > 5'(NUM_EVENTS))
        count_q <= 5'(NUM_EVENTS);
      else
        count_q <= num_events;
    end
  end

  always_comb begin
    next_off = '0;
    for (int i = 0; i < NUM_EVENTS; i++)
      if (i == int'(event_idx) + 1) next_off = off_q[i];
  end

  // Counter is loaded with (cycles - 1) so it reaches zero on the last cycle.
  assign width_load = (width_q == '0) ? '0 : CNT_W'(width_q - 16'd1);
  assign gap_load   = (next_off == '0) ? '0 : next_off - CNT_W'(1);

`ifdef TRIGGER_SEQ_TIMEOUT_EN
  logic timeout_en_q;
  logic timeout_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_en_q <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      if (capture) timeout_en_q <= (timeout != '0);
      timed_out <= timeout_fire;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout;
  assign timed_out      = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    idx_d          = event_idx;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
    timeout_fire   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_ARMED;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
          cnt_load       = 1'b1;
          cnt_load_value = (timeout == '0) ? '0 : timeout - CNT_W'(1);
`endif
        end
      end
      ST_ARMED: begin
        if (trig_edge) begin
          cnt_load = 1'b1;
          if (off_q[0] == '0) begin
            state_d        = ST_PULSE;
            cnt_load_value = width_load;
          end else begin
            state_d        = ST_WAIT_OFFSET;
            cnt_load_value = off_q[0] - CNT_W'(1);
          end
        end
`ifdef TRIGGER_SEQ_TIMEOUT_EN
        else if (timeout_en_q) begin
          if (cnt_zero) begin
            state_d      = ST_IDLE;
            timeout_fire = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
`endif
      end
      ST_WAIT_OFFSET: begin
        if (cnt_zero) begin
          state_d        = ST_PULSE;
          cnt_load       = 1'b1;
          cnt_load_value = width_load;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          if (is_last) begin
            state_d = ST_DONE;
          end else begin
            state_d        = ST_WAIT_OFFSET;
            idx_d          = event_idx + 4'd1;
            cnt_load       = 1'b1;
            cnt_load_value = gap_load;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
      timeout_fire = 1'b0;
`endif
    end
    if (state_d == ST_IDLE || state_d == ST_ARMED) idx_d = '0;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      trig_prev  <= 1'b0;
      glitch_out <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      event_idx  <= '0;
    end else begin
      state_q    <= state_d;
      trig_prev  <= trig_in;
      glitch_out <= (state_d == ST_PULSE);
      armed      <= (state_d == ST_ARMED);
      busy       <= (state_d == ST_WAIT_OFFSET) || (state_d == ST_PULSE);
      done       <= (state_d == ST_DONE);
      event_idx  <= idx_d;
    end
  end

  trigger_seq_counter #(.W(CNT_W)) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized transactions checked against a schedule-based reference model.
module tb_trigger_sequencer;
  import trigger_seq_pkg::*;

  localparam int NE = DEFAULT_NUM_EVENTS;
  localparam int CW = DEFAULT_CNT_W;

  logic            clk = 1'b0;
  logic            reset, arm, abort, trig_in;
  logic [NE*CW-1:0] offsets;
  logic [15:0]     pulse_width;
  logic [4:0]      num_events;
  logic [CW-1:0]   timeout;
  logic            glitch_out, armed, busy, done, timed_out;
  logic [3:0]      event_idx;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  trigger_sequencer #(.NUM_EVENTS(NE), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .abort       (abort),
    .trig_in     (trig_in),
    .offsets     (offsets),
    .pulse_width (pulse_width),
    .num_events  (num_events),
    .timeout     (timeout),
    .glitch_out  (glitch_out),
    .armed       (armed),
    .busy        (busy),
    .event_idx   (event_idx),
    .done        (done),
    .timed_out   (timed_out)
  );

  typedef struct packed {
    logic       glitch;
    logic       armed;
    logic       busy;
    logic       done;
    logic       timed_out;
    logic [3:0] idx;
  } outs_t;

  typedef struct {
    logic  arm;
    logic  trig;
    outs_t exp;
    logic  chk_idx;
  } vec_t;

  localparam outs_t MASK_ALL   = '1;
  localparam outs_t MASK_NOIDX = 9'b1_1111_0000;

  function automatic outs_t mk(input logic g, input logic a, input logic b,
                               input logic d, input logic t, input int idx);
    outs_t o;
    o.glitch = g; o.armed = a; o.busy = b; o.done = d; o.timed_out = t;
    o.idx = 4'(idx);
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input outs_t exp, input outs_t mask);
    logic [8:0] act;
    act = {glitch_out, armed, busy, done, timed_out, event_idx};
    vectors++;
    if ((act & mask) !== (9'(exp) & 9'(mask))) begin
      miscompares++;
      $display("FAIL %s: got glitch=%b armed=%b busy=%b done=%b timed_out=%b idx=%0d, expected glitch=%b armed=%b busy=%b done=%b timed_out=%b idx=%0d (idx checked=%b)",
               name, act[8], act[7], act[6], act[5], act[4], act[3:0],
               exp.glitch, exp.armed, exp.busy, exp.done, exp.timed_out, exp.idx,
               mask.idx[0]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; arm = 1'b0; abort = 1'b0; trig_in = 1'b0;
    step();
    check_outs("reset_state", mk(0, 0, 0, 0, 0, 0), MASK_ALL);
    step();
    reset = 1'b0;
  endtask

  function automatic logic [NE*CW-1:0] pack_offs(input int o0, input int o1,
                                                 input int o2, input int o3);
    logic [NE*CW-1:0] v;
    v = '0;
    v[0*CW +: CW] = CW'(o0);
    v[1*CW +: CW] = CW'(o1);
    v[2*CW +: CW] = CW'(o2);
    v[3*CW +: CW] = CW'(o3);
    return v;
  endfunction

  // Reference model: pulse schedule relative to the trigger cycle T (m = cycles after T).
  task automatic run_txn(input string name, input logic [NE*CW-1:0] offs,
                         input int pw, input int ne, input int gap);
    int n, w, done_t, o;
    int st [NE];
    int en [NE];
    outs_t exp;
    n = (ne == 0) ? 1 : ((ne > NE) ? NE : ne);
    w = (pw == 0) ? 1 : pw;
    for (int i = 0; i < n; i++) begin
      o = int'(offs[i*CW +: CW]);
      st[i] = (i == 0) ? 1 + o : en[i-1] + 1 + ((o == 0) ? 1 : o);
      en[i] = st[i] + w - 1;
    end
    done_t = en[n-1] + 1;

    offsets = offs; pulse_width = 16'(pw); num_events = 5'(ne); timeout = '0;
    trig_in = 1'b0; arm = 1'b1;
    step();
    check_outs({name, "_armed"}, mk(0, 1, 0, 0, 0, 0), MASK_ALL);
    arm = 1'b0;
    for (int g = 0; g < gap; g++) begin
      step();
      check_outs({name, "_wait_trig"}, mk(0, 1, 0, 0, 0, 0), MASK_ALL);
    end
    trig_in = 1'b1;
    for (int m = 1; m <= done_t + 1; m++) begin
      step();
      exp = mk(0, 0, m < done_t, m == done_t, 0, 0);
      for (int i = n - 1; i >= 0; i--)
        if (m <= en[i] && m < done_t) exp.idx = 4'(i);
      for (int i = 0; i < n; i++)
        if (m >= st[i] && m <= en[i]) exp.glitch = 1'b1;
      check_outs(name, exp, (m == done_t) ? MASK_NOIDX : MASK_ALL);
      if (m <= done_t) begin
        trig_in = 1'($urandom);
        arm     = 1'($urandom);
      end
    end
    arm = 1'b0; trig_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{arm: 0, trig: 0, exp: mk(0, 0, 0, 0, 0, 0), chk_idx: 1};
    tbl[1]  = '{arm: 1, trig: 1, exp: mk(0, 1, 0, 0, 0, 0), chk_idx: 1};
    tbl[2]  = '{arm: 0, trig: 1, exp: mk(0, 1, 0, 0, 0, 0), chk_idx: 1};
    tbl[3]  = '{arm: 0, trig: 0, exp: mk(0, 1, 0, 0, 0, 0), chk_idx: 1};
    tbl[4]  = '{arm: 0, trig: 1, exp: mk(1, 0, 1, 0, 0, 0), chk_idx: 1};
    tbl[5]  = '{arm: 0, trig: 0, exp: mk(0, 0, 1, 0, 0, 1), chk_idx: 1};
    tbl[6]  = '{arm: 0, trig: 1, exp: mk(1, 0, 1, 0, 0, 1), chk_idx: 1};
    tbl[7]  = '{arm: 0, trig: 0, exp: mk(0, 0, 1, 0, 0, 2), chk_idx: 1};
    tbl[8]  = '{arm: 1, trig: 0, exp: mk(0, 0, 1, 0, 0, 2), chk_idx: 1};
    tbl[9]  = '{arm: 0, trig: 1, exp: mk(1, 0, 1, 0, 0, 2), chk_idx: 1};
    tbl[10] = '{arm: 0, trig: 0, exp: mk(0, 0, 0, 1, 0, 0), chk_idx: 0};
    tbl[11] = '{arm: 0, trig: 0, exp: mk(0, 0, 0, 0, 0, 0), chk_idx: 1};

    offsets = '0; pulse_width = 16'd1; num_events = 5'd1; timeout = '0;
    do_reset();

    // Three events, offsets {0,0,2}, width 1, trig_in already high at arm time.
    offsets = pack_offs(0, 0, 2, 0); pulse_width = 16'd1; num_events = 5'd3;
    for (int k = 0; k < 12; k++) begin
      arm = tbl[k].arm; trig_in = tbl[k].trig;
      step();
      check_outs($sformatf("table_row%0d", k), tbl[k].exp,
                 tbl[k].chk_idx ? MASK_ALL : MASK_NOIDX);
    end
    arm = 1'b0; trig_in = 1'b0;

    run_txn("single_off5_w3", pack_offs(5, 0, 0, 0), 3, 1, 2);
    run_txn("zero_width_zero_num", pack_offs(0, 7, 7, 7), 0, 0, 0);
    run_txn("num_saturate", pack_offs(1, 0, 3, 1), 2, 31, 1);

    // Abort in the second cycle of a width-4 pulse.
    offsets = pack_offs(0, 0, 0, 0); pulse_width = 16'd4; num_events = 5'd2;
    arm = 1'b1; step(); arm = 1'b0;
    trig_in = 1'b1; step();
    check_outs("abort_pulse_c1", mk(1, 0, 1, 0, 0, 0), MASK_ALL);
    trig_in = 1'b0; step();
    check_outs("abort_pulse_c2", mk(1, 0, 1, 0, 0, 0), MASK_ALL);
    abort = 1'b1; step(); abort = 1'b0;
    check_outs("abort_glitch_low", mk(0, 0, 0, 0, 0, 0), MASK_ALL);
    for (int k = 0; k < 6; k++) begin
      trig_in = 1'(k % 2);
      step();
      check_outs("abort_stays_idle", mk(0, 0, 0, 0, 0, 0), MASK_ALL);
    end
    trig_in = 1'b0;

    // Abort has priority over arm in the same cycle.
    arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
    check_outs("abort_beats_arm", mk(0, 0, 0, 0, 0, 0), MASK_ALL);

    // Reset in the middle of a pulse.
    arm = 1'b1; step(); arm = 1'b0;
    trig_in = 1'b1; step();
    check_outs("reset_pulse_c1", mk(1, 0, 1, 0, 0, 0), MASK_ALL);
    reset = 1'b1; step(); reset = 1'b0; trig_in = 1'b0;
    check_outs("reset_mid_pulse", mk(0, 0, 0, 0, 0, 0), MASK_ALL);
    step();

    // Armed timeout of 10 cycles with no trigger.
    timeout = CW'(10);
    arm = 1'b1; step(); arm = 1'b0;
    check_outs("timeout_armed_entry", mk(0, 1, 0, 0, 0, 0), MASK_ALL);
`ifdef TRIGGER_SEQ_TIMEOUT_EN
    for (int j = 1; j <= 11; j++) begin
      step();
      if (j < 10)       check_outs("timeout_still_armed", mk(0, 1, 0, 0, 0, 0), MASK_ALL);
      else if (j == 10) check_outs("timeout_pulse", mk(0, 0, 0, 0, 1, 0), MASK_ALL);
      else              check_outs("timeout_idle", mk(0, 0, 0, 0, 0, 0), MASK_ALL);
    end
`else
    for (int j = 1; j <= 12; j++) begin
      step();
      check_outs("no_timeout_armed", mk(0, 1, 0, 0, 0, 0), MASK_ALL);
    end
    abort = 1'b1; step(); abort = 1'b0;
    check_outs("no_timeout_abort", mk(0, 0, 0, 0, 0, 0), MASK_ALL);
`endif
    timeout = '0;

    for (int r = 0; r < 40; r++) begin
      run_txn($sformatf("random%0d", r),
              pack_offs(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                        int'($urandom_range(0, 4)), int'($urandom_range(0, 4))),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
